// File: rtl/bird_game_ctrl.sv
// Frame-rate Flappy Bird controller: sequences game state, bird physics, pipe
// scrolling/respawn, collision and score once per frame_start pulse.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for the first flap, scene at home values
// S_PLAY  | bird under gravity/flap control, pipe scrolling, scoring
// S_DYING | bird hit a pipe, pipe frozen, bird falls to the floor
// S_OVER  | bird on the floor, scene frozen until a flap restarts
module bird_game_ctrl #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int BIRD_X    = 160,
  parameter int BIRD_SIZE = 24,
  parameter int GRAVITY   = 1,
  parameter int FLAP_V    = 9,
  parameter int VMAX      = 12,
  parameter int PIPE_W    = 64,
  parameter int GAP_H     = 140,
  parameter int GAP_MIN   = 40,
  parameter int SCROLL    = 2
) (
  input  logic        pix_clk,
  input  logic        pix_rst,
  input  logic        frame_start,
  input  logic        btn_flap,
  output logic [1:0]  game_state,
  output logic [15:0] bird_y,
  output logic [15:0] pipe_x,
  output logic [15:0] gap_y,
  output logic [15:0] score
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_DYING = 2'd2, S_OVER = 2'd3} state_t;

  localparam logic [15:0]        Y_HOME   = 16'((SCREEN_H - BIRD_SIZE) / 2);
  localparam logic [15:0]        Y_FLOOR  = 16'(SCREEN_H - BIRD_SIZE);
  localparam logic [15:0]        X_SPAWN  = 16'(SCREEN_W + PIPE_W);
  localparam logic [15:0]        GAP_HOME = 16'd170;
  localparam logic [15:0]        GAP_BASE = 16'(GAP_MIN);
  localparam logic [15:0]        X_BIRD   = 16'(BIRD_X);
  localparam logic [15:0]        X_HIT_HI = 16'(BIRD_X + BIRD_SIZE + PIPE_W);
  localparam logic [15:0]        STEP     = 16'(SCROLL);
  localparam logic [16:0]        BSZ17    = 17'(BIRD_SIZE);
  localparam logic [16:0]        GAPH17   = 17'(GAP_H);
  localparam logic signed [16:0] FLOOR_S  = 17'(SCREEN_H - BIRD_SIZE);
  localparam logic signed [7:0]  V_FLAP   = 8'(-FLAP_V);
  localparam logic signed [7:0]  V_MAX    = 8'(VMAX);
  localparam logic signed [7:0]  V_GRAV   = 8'(GRAVITY);

  state_t             state_q, state_d;
  logic signed [7:0]  vel_q, vel_d;
  logic [15:0]        bird_y_q, bird_y_d, pipe_x_q, pipe_x_d;
  logic [15:0]        gap_y_q, gap_y_d, score_q, score_d;
  logic [7:0]         lfsr_q;
  logic               flap_pending_q, btn_d_q;

  logic               flap_edge, flap;
  logic signed [7:0]  vel_fall, vel_play;
  logic signed [16:0] y_play, y_fall;
  logic [15:0]        pipe_move, gap_move, bird_play;
  logic               hit_x, hit_y;

  assign flap_edge = btn_flap & ~btn_d_q;
  // an edge in the frame_start cycle itself still counts for this frame
  assign flap      = flap_pending_q | flap_edge;

  assign vel_fall  = (vel_q >= V_MAX) ? V_MAX : vel_q + V_GRAV;
  assign vel_play  = flap ? V_FLAP : vel_fall;
  assign y_play    = $signed({1'b0, bird_y_q}) + $signed({{9{vel_play[7]}}, vel_play});
  assign y_fall    = $signed({1'b0, bird_y_q}) + $signed({{9{vel_fall[7]}}, vel_fall});

  assign pipe_move = (pipe_x_q <= STEP) ? X_SPAWN : pipe_x_q - STEP;
  assign gap_move  = (pipe_x_q <= STEP) ? GAP_BASE + {8'd0, lfsr_q} : gap_y_q;
  assign bird_play = y_play[16] ? 16'd0 : y_play[15:0];

  // overlap test rearranged as pipe_x < BIRD_X+BIRD_SIZE+PIPE_W to avoid underflow
  assign hit_x = (pipe_move > X_BIRD) && (pipe_move < X_HIT_HI);
  assign hit_y = (bird_play < gap_move) ||
                 (({1'b0, bird_play} + BSZ17) > ({1'b0, gap_move} + GAPH17));

  always_comb begin
    state_d  = state_q;
    vel_d    = vel_q;
    bird_y_d = bird_y_q;
    pipe_x_d = pipe_x_q;
    gap_y_d  = gap_y_q;
    score_d  = score_q;
    if (frame_start) begin
      case (state_q)
        S_IDLE: begin
          if (flap) begin
            state_d = S_PLAY;
            vel_d   = V_FLAP;
          end
        end
        S_PLAY: begin
          pipe_x_d = pipe_move;
          gap_y_d  = gap_move;
          if (pipe_x_q > X_BIRD && pipe_move <= X_BIRD && score_q != 16'hFFFF)
            score_d = score_q + 16'd1;
          if (y_play >= FLOOR_S) begin
            bird_y_d = Y_FLOOR;
            vel_d    = vel_play;
            state_d  = S_OVER;
          end else begin
            bird_y_d = bird_play;
            vel_d    = y_play[16] ? 8'sd0 : vel_play;
            if (hit_x && hit_y)
              state_d = S_DYING;
          end
        end
        S_DYING: begin
          vel_d = vel_fall;
          if (y_fall >= FLOOR_S) begin
            bird_y_d = Y_FLOOR;
            state_d  = S_OVER;
          end else begin
            bird_y_d = y_fall[16] ? 16'd0 : y_fall[15:0];
          end
        end
        S_OVER: begin
          if (flap) begin
            state_d  = S_IDLE;
            vel_d    = 8'sd0;
            bird_y_d = Y_HOME;
            pipe_x_d = X_SPAWN;
            gap_y_d  = GAP_HOME;
            score_d  = 16'd0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge pix_clk or posedge pix_rst) begin
    if (pix_rst) begin
      state_q        <= S_IDLE;
      vel_q          <= 8'sd0;
      bird_y_q       <= Y_HOME;
      pipe_x_q       <= X_SPAWN;
      gap_y_q        <= GAP_HOME;
      score_q        <= 16'd0;
      lfsr_q         <= 8'hA5;
      flap_pending_q <= 1'b0;
      btn_d_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      vel_q          <= vel_d;
      bird_y_q       <= bird_y_d;
      pipe_x_q       <= pipe_x_d;
      gap_y_q        <= gap_y_d;
      score_q        <= score_d;
      lfsr_q         <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      flap_pending_q <= frame_start ? 1'b0 : (flap_pending_q | flap_edge);
      btn_d_q        <= btn_flap;
    end
  end

  assign game_state = state_q;
  assign bird_y     = bird_y_q;
  assign pipe_x     = pipe_x_q;
  assign gap_y      = gap_y_q;
  assign score      = score_q;

endmodule

// File: tb/tb_bird_game_ctrl.sv
// Directed bench for bird_game_ctrl: vector table for the opening flight plus
// hand-written sequences for reset, flap capture, scoring, respawn and collision.
module tb_bird_game_ctrl;

  logic        pix_clk = 1'b0;
  logic        pix_rst;
  logic        frame_start;
  logic        btn_flap;
  logic [1:0]  game_state;
  logic [15:0] bird_y, pipe_x, gap_y, score;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit flap;
    int st;
    int y;
    int px;
  } vec_t;

  vec_t vecs[23];
  int   nvec = 0;

  bird_game_ctrl dut (
    .pix_clk    (pix_clk),
    .pix_rst    (pix_rst),
    .frame_start(frame_start),
    .btn_flap   (btn_flap),
    .game_state (game_state),
    .bird_y     (bird_y),
    .pipe_x     (pipe_x),
    .gap_y      (gap_y),
    .score      (score)
  );

  always #5 pix_clk = ~pix_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge pix_clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic frame(input bit f);
    if (f) begin
      btn_flap = 1'b1;
      tick();
      btn_flap = 1'b0;
    end
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    pix_rst = 1'b1;
    tick();
    tick();
    pix_rst = 1'b0;
    tick();
  endtask

  task automatic chk_home(input string tag);
    chk({tag, "_state"}, int'(game_state), 0);
    chk({tag, "_y"},     int'(bird_y),     228);
    chk({tag, "_px"},    int'(pipe_x),     704);
    chk({tag, "_gap"},   int'(gap_y),      170);
    chk({tag, "_score"}, int'(score),      0);
  endtask

  task automatic add_vec(input bit f, input int y, input int px);
    vecs[nvec] = '{flap: f, st: 1, y: y, px: px};
    nvec++;
  endtask

  initial begin
    int  n;
    int  exp_pipe;
    int  exp_score;
    bit  wrapped;
    bit  f;

    add_vec(1'b1, 228, 704); add_vec(1'b0, 220, 702); add_vec(1'b0, 213, 700);
    add_vec(1'b0, 207, 698); add_vec(1'b0, 202, 696); add_vec(1'b0, 198, 694);
    add_vec(1'b0, 195, 692); add_vec(1'b0, 193, 690); add_vec(1'b0, 192, 688);
    add_vec(1'b0, 192, 686); add_vec(1'b0, 193, 684); add_vec(1'b0, 195, 682);
    add_vec(1'b0, 198, 680); add_vec(1'b0, 202, 678); add_vec(1'b0, 207, 676);
    add_vec(1'b0, 213, 674); add_vec(1'b0, 220, 672); add_vec(1'b0, 228, 670);
    add_vec(1'b0, 237, 668); add_vec(1'b0, 247, 666); add_vec(1'b0, 258, 664);
    add_vec(1'b0, 270, 662); add_vec(1'b0, 282, 660);

    pix_rst     = 1'b1;
    frame_start = 1'b0;
    btn_flap    = 1'b0;
    tick();
    tick();
    pix_rst = 1'b0;
    tick();
    chk_home("reset");

    // asynchronous reset in the middle of play
    frame(1'b1);
    frame(1'b0);
    frame(1'b0);
    chk("pre_rst_state", int'(game_state), 1);
    chk("pre_rst_y", int'(bird_y), 213);
    pix_rst = 1'b1;
    #2;
    chk_home("async_rst");
    tick();
    tick();
    tick();
    pix_rst = 1'b0;
    tick();
    chk_home("post_rst");

    // opening flight from IDLE, velocity saturating at VMAX
    for (int i = 0; i < nvec; i++) begin
      frame(vecs[i].flap);
      chk($sformatf("vec%0d_state", i), int'(game_state), vecs[i].st);
      chk($sformatf("vec%0d_y", i),     int'(bird_y),     vecs[i].y);
      chk($sformatf("vec%0d_px", i),    int'(pipe_x),     vecs[i].px);
    end

    n = 0;
    while (game_state != 2'd3 && n < 40) begin
      frame(1'b0);
      n++;
    end
    chk("floor_frames", n, 15);
    chk("floor_state", int'(game_state), 3);
    chk("floor_y", int'(bird_y), 456);
    chk("floor_px", int'(pipe_x), 630);
    frame(1'b0);
    frame(1'b0);
    chk("over_hold_state", int'(game_state), 3);
    chk("over_hold_y", int'(bird_y), 456);
    chk("over_hold_px", int'(pipe_x), 630);
    chk("over_hold_gap", int'(gap_y), 170);
    frame(1'b1);
    chk_home("restart_a");

    // flap capture: two edges in a frame, edge coincident with frame_start
    frame(1'b1);
    chk("dbl_start_state", int'(game_state), 1);
    btn_flap = 1'b1; tick();
    btn_flap = 1'b0; tick();
    btn_flap = 1'b1; tick();
    btn_flap = 1'b0; tick();
    frame_start = 1'b1; tick();
    frame_start = 1'b0;
    chk("dbl_edge_y", int'(bird_y), 219);
    btn_flap    = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("coincident_y", int'(bird_y), 210);
    tick();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("held_btn_y", int'(bird_y), 202);
    btn_flap = 1'b0;
    frame(1'b0);
    chk("after_held_y", int'(bird_y), 195);

    // keep the bird in the gap while the pipe passes and respawns
    do_reset();
    frame(1'b1);
    exp_pipe  = 704;
    exp_score = 0;
    wrapped   = 1'b0;
    for (int i = 0; i < 400 && !wrapped; i++) begin
      f = (bird_y > 16'd240);
      frame(f);
      if (exp_pipe <= 2) begin
        exp_pipe = 704;
        wrapped  = 1'b1;
      end else begin
        exp_pipe = exp_pipe - 2;
      end
      if (exp_pipe == 160) exp_score = 1;
      chk("score_px", int'(pipe_x), exp_pipe);
      chk("score_cnt", int'(score), exp_score);
      chk("score_state", int'(game_state), 1);
      if (exp_pipe == 160) chk("score_gap", int'(gap_y), 170);
      if (wrapped) begin
        total++;
        if (gap_y < 16'd41 || gap_y > 16'd295) begin
          bad++;
          $display("FAIL respawn_gap: got %0d expected 41..295", gap_y);
        end
      end
    end

    n = 0;
    while (game_state != 2'd3 && n < 60) begin
      frame(1'b0);
      n++;
    end
    chk("score_over_state", int'(game_state), 3);
    chk("score_over_y", int'(bird_y), 456);
    chk("score_over_cnt", int'(score), 1);
    frame(1'b1);
    chk_home("restart_b");

    // bird pinned at the ceiling runs into the pipe
    do_reset();
    frame(1'b1);
    n = 0;
    while (pipe_x != 16'd248 && n < 300) begin
      frame(1'b1);
      n++;
    end
    chk("coll_approach", n, 228);
    chk("coll_pre_state", int'(game_state), 1);
    chk("coll_pre_y", int'(bird_y), 0);
    frame(1'b1);
    chk("coll_state", int'(game_state), 2);
    chk("coll_px", int'(pipe_x), 246);
    chk("coll_y", int'(bird_y), 0);
    frame(1'b1);
    chk("dying_flap_y", int'(bird_y), 1);
    chk("dying_flap_state", int'(game_state), 2);
    frame(1'b0);
    chk("dying_y2", int'(bird_y), 3);
    n = 0;
    while (game_state != 2'd3 && n < 60) begin
      frame(1'b0);
      chk("dying_px", int'(pipe_x), 246);
      n++;
    end
    chk("dead_state", int'(game_state), 3);
    chk("dead_y", int'(bird_y), 456);
    chk("dead_px", int'(pipe_x), 246);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
